// File: rtl/int_pkg.sv
// Shared types, width helpers and default vector constants for the nested interrupt controller.
package int_pkg;

  typedef enum logic {StIdle, StReq} int_state_e;

  localparam logic [31:0] VecBaseDefault   = 32'h0000_30AC;
  localparam logic [31:0] VecStrideDefault = 32'h0000_00C4;

  function automatic int unsigned idw_f(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int unsigned lw_f(input int unsigned nch);
    return $clog2(nch + 1);
  endfunction

  function automatic int unsigned dw_f(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Highest-set-bit encoder: idx_o is the index of the most significant set bit of req_i.
module prio_enc
  import int_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = idw_f(N)
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nested_int_ctrl.sv
// Nested interrupt controller: edge-latched pending bits, level-based arbitration, a registered
// request to the pipeline and a return-PC stack pushed on ack and popped on uret.
module nested_int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned     NCH        = 3,
  parameter int unsigned     DEPTH      = 3,
  parameter int unsigned     WIDTH      = 32,
  parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(VecBaseDefault),
  parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(VecStrideDefault),
  parameter bit              IE_RST     = 1'b1,
  localparam int unsigned    IDW        = idw_f(NCH),
  localparam int unsigned    LW         = lw_f(NCH),
  localparam int unsigned    DW         = dw_f(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NCH-1:0]   irq_i,
  input  logic             ie_we_i,
  input  logic             ie_din_i,
  input  logic             epc_we_i,
  input  logic [WIDTH-1:0] epc_din_i,
  input  logic             int_ack_i,
  input  logic [WIDTH-1:0] ack_pc_i,
  input  logic             int_ret_i,
  output logic             int_req_o,
  output logic [IDW-1:0]   int_id_o,
  output logic [WIDTH-1:0] int_vec_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             ie_o,
  output logic [NCH-1:0]   irw_o,
  output logic [LW-1:0]    cur_level_o,
  output logic [DW-1:0]    depth_o,
  output logic             err_o
);

  int_state_e       state_q, state_d;
  logic [NCH-1:0]   irq_q, irw_q, irw_d, clr;
  logic             ie_q, ie_d, req_q, req_d, err_q, err_d;
  logic [IDW-1:0]   id_q, id_d, p_idx;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] stk_pc_q  [DEPTH];
  logic [WIDTH-1:0] stk_pc_d  [DEPTH];
  logic [LW-1:0]    stk_lvl_q [DEPTH];
  logic [LW-1:0]    stk_lvl_d [DEPTH];
  logic             p_valid, elig, ack_fire, ret_fire;

  prio_enc #(.N(NCH), .IW(IDW)) u_prio_enc (
    .req_i   (irw_q),
    .idx_o   (p_idx),
    .valid_o (p_valid)
  );

  assign elig = ie_q && p_valid && (depth_q < DW'(DEPTH)) && ((LW'(p_idx) + LW'(1)) > lvl_q);
  assign ack_fire = (state_q == StReq) && int_ack_i;
  // A simultaneous ack always wins over uret.
  assign ret_fire = int_ret_i && !int_ack_i && (depth_q != '0);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    id_d      = id_q;
    vec_d     = vec_q;
    ie_d      = ie_q;
    lvl_d     = lvl_q;
    depth_d   = depth_q;
    stk_pc_d  = stk_pc_q;
    stk_lvl_d = stk_lvl_q;
    err_d     = err_q | (int_ack_i && (state_q == StIdle)) | (int_ack_i && int_ret_i)
                      | (int_ret_i && (depth_q == '0));
    clr       = ack_fire ? (NCH'(1) << id_q) : '0;
    irw_d     = (irw_q & ~clr) | (irq_i & ~irq_q);

    unique case (state_q)
      StIdle: begin
        if (elig) begin
          state_d = StReq;
          req_d   = 1'b1;
          id_d    = p_idx;
          vec_d   = VEC_BASE + WIDTH'(p_idx) * VEC_STRIDE;
        end
      end
      StReq: begin
        if (int_ack_i || (ie_we_i && !ie_din_i)) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (ack_fire) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (DW'(i) == depth_q) begin
          stk_pc_d[i]  = ack_pc_i;
          stk_lvl_d[i] = lvl_q;
        end
      end
      lvl_d   = LW'(id_q) + LW'(1);
      depth_d = depth_q + DW'(1);
      ie_d    = 1'b0;
    end else if (ret_fire) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (DW'(i) == depth_q - DW'(1)) begin
          lvl_d        = stk_lvl_q[i];
          stk_pc_d[i]  = '0;
          stk_lvl_d[i] = '0;
        end
      end
      depth_d = depth_q - DW'(1);
      ie_d    = 1'b1;
    end else begin
      if (ie_we_i) ie_d = ie_din_i;
      if (epc_we_i && (depth_q != '0)) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (DW'(i) == depth_q - DW'(1)) stk_pc_d[i] = epc_din_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      irq_q   <= '0;
      irw_q   <= '0;
      ie_q    <= IE_RST;
      req_q   <= 1'b0;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
      lvl_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stk_pc_q[i]  <= '0;
        stk_lvl_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_i;
      irw_q     <= irw_d;
      ie_q      <= ie_d;
      req_q     <= req_d;
      id_q      <= id_d;
      vec_q     <= vec_d;
      lvl_q     <= lvl_d;
      depth_q   <= depth_d;
      err_q     <= err_d;
      stk_pc_q  <= stk_pc_d;
      stk_lvl_q <= stk_lvl_d;
    end
  end

  always_comb begin
    epc_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((depth_q != '0) && (DW'(i) == depth_q - DW'(1))) epc_o = stk_pc_q[i];
    end
  end

  assign int_req_o   = req_q;
  assign int_id_o    = id_q;
  assign int_vec_o   = vec_q;
  assign ie_o        = ie_q;
  assign irw_o       = irw_q;
  assign cur_level_o = lvl_q;
  assign depth_o     = depth_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_nested_int_ctrl.sv
// Randomised bench for nested_int_ctrl, checked against a queue-based model of the service stack.
module tb_nested_int_ctrl;

  localparam int unsigned NCH   = 3;
  localparam int unsigned DEPTH = 3;
  localparam logic [31:0] VBASE = 32'h0000_30AC;
  localparam logic [31:0] VSTEP = 32'h0000_00C4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [2:0]  irq_i = '0;
  logic        ie_we_i = 1'b0, ie_din_i = 1'b0, epc_we_i = 1'b0, int_ack_i = 1'b0;
  logic        int_ret_i = 1'b0;
  logic [31:0] epc_din_i = '0, ack_pc_i = '0;
  logic        int_req_o, ie_o, err_o;
  logic [1:0]  int_id_o, cur_level_o, depth_o;
  logic [31:0] int_vec_o, epc_o;
  logic [2:0]  irw_o;

  nested_int_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .irq_i       (irq_i),
    .ie_we_i     (ie_we_i),
    .ie_din_i    (ie_din_i),
    .epc_we_i    (epc_we_i),
    .epc_din_i   (epc_din_i),
    .int_ack_i   (int_ack_i),
    .ack_pc_i    (ack_pc_i),
    .int_ret_i   (int_ret_i),
    .int_req_o   (int_req_o),
    .int_id_o    (int_id_o),
    .int_vec_o   (int_vec_o),
    .epc_o       (epc_o),
    .ie_o        (ie_o),
    .irw_o       (irw_o),
    .cur_level_o (cur_level_o),
    .depth_o     (depth_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          lvl;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_stk[$];
  logic [2:0]  m_prev, m_pend;
  int          m_lvl, m_id;
  bit          m_ie, m_req, m_err;
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_prev = '0;
    m_pend = '0;
    m_lvl  = 0;
    m_id   = 0;
    m_ie   = 1'b1;
    m_req  = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic check_all();
    logic [31:0] exp_epc, exp_vec;
    exp_epc = (m_stk.size() == 0) ? 32'h0 : m_stk[m_stk.size()-1].pc;
    exp_vec = VBASE + 32'(m_id) * VSTEP;
    check("int_req", 64'(int_req_o), 64'(m_req));
    check("int_id", 64'(int_id_o), 64'(m_id));
    check("int_vec", 64'(int_vec_o), 64'(exp_vec));
    check("epc", 64'(epc_o), 64'(exp_epc));
    check("ie", 64'(ie_o), 64'(m_ie));
    check("irw", 64'(irw_o), 64'(m_pend));
    check("cur_level", 64'(cur_level_o), 64'(m_lvl));
    check("depth", 64'(depth_o), 64'(m_stk.size()));
    check("err", 64'(err_o), 64'(m_err));
  endtask

  task automatic model_cycle(input logic [2:0] irq, input logic iwe, idin, ewe,
                             input logic [31:0] edin, input logic ack,
                             input logic [31:0] apc, input logic ret);
    int   hi;
    bit   elig, old_req;
    ent_t e;
    hi = -1;
    for (int k = 0; k < NCH; k++) if (m_pend[k]) hi = k;
    elig = m_ie && (hi >= 0) && (m_stk.size() < DEPTH) && (hi + 1 > m_lvl);
    old_req = m_req;
    if ((ack && !m_req) || (ack && ret) || (ret && m_stk.size() == 0)) m_err = 1'b1;
    if (m_req && ack) begin
      e.lvl = m_lvl;
      e.pc  = apc;
      m_stk.push_back(e);
      m_lvl = m_id + 1;
      m_ie  = 1'b0;
      m_pend[m_id] = 1'b0;
    end else if (ret && !ack && m_stk.size() > 0) begin
      e     = m_stk.pop_back();
      m_lvl = e.lvl;
      m_ie  = 1'b1;
    end else begin
      if (iwe) m_ie = idin;
      if (ewe && m_stk.size() > 0) begin
        e    = m_stk.pop_back();
        e.pc = edin;
        m_stk.push_back(e);
      end
    end
    if (old_req) begin
      if (ack || (iwe && !idin)) m_req = 1'b0;
    end else if (elig) begin
      m_req = 1'b1;
      m_id  = hi;
    end
    m_pend = m_pend | (irq & ~m_prev);
    m_prev = irq;
  endtask

  task automatic step(input logic [2:0] irq, input logic iwe, idin, ewe,
                      input logic [31:0] edin, input logic ack,
                      input logic [31:0] apc, input logic ret);
    @(negedge clk_i);
    irq_i = irq; ie_we_i = iwe; ie_din_i = idin; epc_we_i = ewe; epc_din_i = edin;
    int_ack_i = ack; ack_pc_i = apc; int_ret_i = ret;
    model_cycle(irq, iwe, idin, ewe, edin, ack, apc, ret);
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic [2:0] irq_during);
    @(negedge clk_i);
    rst_ni = 1'b0;
    irq_i = irq_during; ie_we_i = 0; epc_we_i = 0; int_ack_i = 0; int_ret_i = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clk_i);
    irq_i  = '0;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [2:0]  r_irq;
    logic [31:0] pc;
    model_reset();
    r_irq = '0;
    do_reset(3'b111);
    check("rst_ie", 64'(ie_o), 64'd1);

    // Single interrupt on channel 0.
    step(3'b001, 0, 0, 0, 0, 0, 0, 0);
    check("single_irw", 64'(irw_o), 64'h1);
    step(3'b000, 0, 0, 0, 0, 0, 0, 0);
    check("single_vec", 64'(int_vec_o), 64'h30AC);
    step(3'b000, 0, 0, 0, 0, 1, 32'h100, 0);
    check("single_epc", 64'(epc_o), 64'h100);

    // Nest channel 2 inside channel 0.
    step(3'b000, 1, 1, 0, 0, 0, 0, 0);
    step(3'b100, 0, 0, 0, 0, 0, 0, 0);
    step(3'b000, 0, 0, 0, 0, 0, 0, 0);
    check("nest_vec", 64'(int_vec_o), 64'h3234);
    step(3'b000, 0, 0, 0, 0, 1, 32'h200, 0);
    check("nest_depth", 64'(depth_o), 64'd2);
    step(3'b000, 1, 1, 0, 0, 0, 0, 0);
    step(3'b010, 0, 0, 0, 0, 0, 0, 0);
    step(3'b000, 0, 0, 0, 0, 0, 0, 0);
    check("block_req", 64'(int_req_o), 64'd0);
    step(3'b000, 0, 0, 0, 0, 0, 0, 1);
    check("ret_epc", 64'(epc_o), 64'h100);
    step(3'b000, 0, 0, 0, 0, 0, 0, 0);
    check("unblock_vec", 64'(int_vec_o), 64'h3170);

    // Withdraw during REQ, then ack+ret collision and ret at depth 0.
    step(3'b000, 1, 0, 0, 0, 0, 0, 0);
    check("withdraw_irw", 64'(irw_o), 64'h2);
    step(3'b000, 1, 1, 0, 0, 0, 0, 0);
    step(3'b000, 0, 0, 0, 0, 0, 0, 0);
    step(3'b000, 0, 0, 0, 0, 1, 32'h300, 1);
    check("collide_err", 64'(err_o), 64'd1);
    for (int i = 0; i < 4; i++) step(3'b000, 0, 0, 0, 0, 0, 0, 1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic ack, ret, iwe, ewe;
      if ($urandom_range(0, 599) == 0) do_reset(3'($urandom));
      r_irq = r_irq ^ ((($urandom_range(0, 3) == 0)) ? 3'($urandom) : 3'b000);
      ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      ret = ($urandom_range(0, 9) == 0);
      iwe = ($urandom_range(0, 5) == 0);
      ewe = ($urandom_range(0, 9) == 0);
      pc  = $urandom;
      step(r_irq, iwe, 1'($urandom), ewe, $urandom, ack, pc, ret);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/nested_int_ctrl.md
Name: nested_int_ctrl

Overview:
- Parametrised interrupt controller for the interrupt pipeline CPU. It replaces the fixed 3-line IR/IE/IRS/EPC/IP register cluster with a controller of NCH channels and a nesting stack DEPTH deep.
- It latches request edges, arbitrates by priority against the current in-service level, and presents a registered request, channel id and vector to the pipeline.
- On pipeline ack it pushes the return PC; on uret it pops it.

Parameters:
- NCH, 3: number of interrupt channels. Higher index means higher priority.
- DEPTH, 3: nesting stack depth, 1..NCH.
- WIDTH, 32: PC/EPC width.
- VEC_BASE, 32'h000030AC: handler address for channel 0.
- VEC_STRIDE, 32'h000000C4: address step per channel. Vector = VEC_BASE + id*VEC_STRIDE.
- IE_RST, 1: reset value of global interrupt enable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- irq  in  NCH  synchronous request lines, rising-edge sensitive.
- ie_we  in  1  CSR write strobe for IE.
- ie_din  in  1  IE write data.
- epc_we  in  1  CSR write strobe for top-of-stack EPC.
- epc_din  in  WIDTH  EPC write data.
- int_ack  in  1  pipeline committed the hidden interrupt-entry instruction.
- ack_pc  in  WIDTH  return PC captured with int_ack.
- int_ret  in  1  uret reached WB.
- int_req  out  1  interrupt entry request (registered).
- int_id  out  IDW  requested channel; IDW = max(1, clog2(NCH)).
- int_vec  out  WIDTH  handler address for int_id.
- epc  out  WIDTH  top-of-stack return PC (0 when the stack is empty).
- ie  out  1  global enable.
- irw  out  NCH  pending bits (lamp outputs).
- cur_level  out  LW  in-service level: 0 = none, channel k = k+1. LW = clog2(NCH+1).
- depth  out  DW  stack occupancy; DW = clog2(DEPTH+1).
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (rst=0, async): int_req=0, int_id=0, int_vec=VEC_BASE, epc=0, ie=IE_RST, irw=0, cur_level=0, depth=0, err=0, FSM=IDLE. Stack entries cleared.
- Edge detect: irq_q registers irq. A bit where irq & ~irq_q sets irw[k] at the same edge.
  - irw[k] clears only at the ack of channel k.
  - A set and a clear of the same bit in one cycle: set wins.
- Eligibility (combinational): p = highest set irw bit. elig = ie && irw!=0 && depth<DEPTH && (p+1) > cur_level.
- FSM IDLE:
  - On elig, go to REQ at the next edge.
  - int_req=1; int_id=p; int_vec=VEC_BASE+p*VEC_STRIDE, using WIDTH-bit wrap arithmetic.
- FSM REQ: int_req, int_id and int_vec are held frozen, even if a higher-priority request arrives.
  - int_ack: at the next edge, push {cur_level, ack_pc}; cur_level=int_id+1; depth+1; ie=0; clear irw[int_id]; go to IDLE.
  - ie_we with ie_din=0 and no int_ack: withdraw. int_req=0 at the next edge, irw unchanged, go to IDLE.
- Latency: irq rise sampled at edge k → irw set after edge k → int_req high after edge k+1.
- int_ret, with depth>0, in IDLE or REQ:
  - Pop the stack; cur_level = saved level; depth-1; ie=1.
  - epc shows the new top after the same edge.
  - If int_ret arrives in REQ, the frozen request stays valid.
- int_ret with depth=0: ignored; err=1.
- int_ack while in IDLE: ignored; err=1.
- int_ack and int_ret in the same cycle: the ack is processed, the ret is ignored, err=1.
- ie_we: ie=ie_din at the next edge. An ack or ret in the same cycle overrides it.
- epc_we with depth>0: overwrite the top entry PC. With depth=0: ignored.
- Pending bits for channels at or below cur_level stay latched. They are served after the level drops.
- Reset mid-service: all state is discarded; no pending bit survives.

Decomposition:
- Package int_pkg holds:
  - FSM state enum {IDLE, REQ}.
  - Helper functions for IDW, LW and DW.
  - Default VEC_BASE and VEC_STRIDE constants.
- One sub-module: prio_enc #(N), a highest-set-bit encoder with outputs idx and valid. It replaces the one-hot highbit use.

Test Plan:
1. Reset: hold rst=0 with irq=3'b111 → int_req=0, irw=000, depth=0, ie=1, epc=0, err=0 after release.
2. Single interrupt:
   - irq[0] pulse → irw=001, then int_req=1 with int_id=0, int_vec=0x30AC.
   - int_ack with ack_pc=0x100 → depth=1, cur_level=1, ie=0, epc=0x100, irw=000.
3. Nesting:
   - In ch0 service, ie_we/ie_din=1, then irq[2] → int_req with id 2, vec 0x3234.
   - ack with pc 0x200 → depth=2, epc=0x200.
   - First int_ret → epc=0x100, cur_level=1, ie=1. Second int_ret → depth=0, cur_level=0.
4. Priority block:
   - Serving ch2 with ie=1, irq[1] → irw=010, int_req stays 0.
   - After int_ret → int_req, id 1, vec 0x3170.
5. Simultaneous irq=011 → id 1 is served first; after ack and ret, id 0 is requested with vec 0x30AC.
6. Errors:
   - int_ret at depth 0 → err=1, other state unchanged.
   - ie_din=0 written during REQ → int_req=0 next cycle, irw retained.
   - int_ack and int_ret in the same cycle → ack applied, err=1.
